// File: rtl/jzjpcc_fetch_pkg.sv
// Shared types and sizing helpers for the fetch sequencer.
// The INIT down-counter width follows INIT_CYCLES, which is only known at the instantiation site.
package jzjpcc_fetch_pkg;

    typedef enum logic [1:0] {FS_INIT, FS_RUN, FS_HALT} fetchState_t;

    function automatic int fetch_init_cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

    localparam int INIT_CNT_W_DEFAULT = fetch_init_cnt_w(2);

endpackage

// File: rtl/jzjpcc_redirect_arbiter.sv
// Priority logic for RUN-state fetch control: halt > branch > load-use hazard > jump.
module jzjpcc_redirect_arbiter
    import jzjpcc_fetch_pkg::*;
#(
    parameter int PC_MAX_B = 31
) (
    input  logic                haltRequest,
    input  logic                executeBranchRequest,
    input  logic [PC_MAX_B:2]   executeBranchTarget,
    input  logic                loadUseHazard,
    input  logic                decodeJumpRequest,
    input  logic [PC_MAX_B:2]   decodeJumpTarget,
    output logic                stall_fetch,
    output logic                stall_decode,
    output logic                pcCTWriteEnable,
    output logic [PC_MAX_B:2]   controlTransferNewPC,
    output logic                flush_fetch,
    output logic                flush_decode
);

    // A branch squashes the younger hazard/jump instructions; a hazard defers the jump by holding decode.
    always_comb begin
        stall_fetch          = 1'b0;
        stall_decode         = 1'b0;
        pcCTWriteEnable      = 1'b0;
        controlTransferNewPC = '0;
        flush_fetch          = 1'b0;
        flush_decode         = 1'b0;
        if (haltRequest) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            flush_decode = 1'b1;
        end else if (executeBranchRequest) begin
            pcCTWriteEnable      = 1'b1;
            controlTransferNewPC = executeBranchTarget;
            flush_fetch          = 1'b1;
            flush_decode         = 1'b1;
        end else if (loadUseHazard) begin
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
            flush_decode = 1'b1;
        end else if (decodeJumpRequest) begin
            pcCTWriteEnable      = 1'b1;
            controlTransferNewPC = decodeJumpTarget;
            flush_fetch          = 1'b1;
        end
    end

endmodule

// File: rtl/jzjpcc_fetch_sequencer.sv
// Fetch-stage sequencer: INIT while instruction SRAM primes, then RUN with redirect/stall arbitration, HALT until reset.
// Outputs are Mealy so the PC's nextPC can be captured by the imem address register in the same cycle.
module jzjpcc_fetch_sequencer
    import jzjpcc_fetch_pkg::*;
#(
    parameter int PC_MAX_B    = 31,
    parameter int INIT_CYCLES = 2,
    parameter int STAT_W      = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                decodeJumpRequest,
    input  logic [PC_MAX_B:2]   decodeJumpTarget,
    input  logic                executeBranchRequest,
    input  logic [PC_MAX_B:2]   executeBranchTarget,
    input  logic                loadUseHazard,
    input  logic                haltRequest,
    output logic                initialize,
    output logic                stall_fetch,
    output logic                pcCTWriteEnable,
    output logic [PC_MAX_B:2]   controlTransferNewPC,
    output logic                stall_decode,
    output logic                flush_fetch,
    output logic                flush_decode,
    output logic                halted,
    output logic [STAT_W-1:0]   statBubbles
);

    localparam int CNT_W = fetch_init_cnt_w(INIT_CYCLES);
    localparam logic [CNT_W-1:0] INIT_RELOAD = CNT_W'(INIT_CYCLES - 1);

    if (INIT_CYCLES < 1) begin : g_bad_init_cycles
        $fatal(1, "jzjpcc_fetch_sequencer: INIT_CYCLES must be at least 1");
    end

    fetchState_t        state;
    logic [CNT_W-1:0]   init_cnt;
    logic               bubble;

    logic               arb_stall_fetch;
    logic               arb_stall_decode;
    logic               arb_ct_we;
    logic [PC_MAX_B:2]  arb_ct_pc;
    logic               arb_flush_fetch;
    logic               arb_flush_decode;

    jzjpcc_redirect_arbiter #(
        .PC_MAX_B(PC_MAX_B)
    ) u_arbiter (
        .haltRequest          (haltRequest),
        .executeBranchRequest (executeBranchRequest),
        .executeBranchTarget  (executeBranchTarget),
        .loadUseHazard        (loadUseHazard),
        .decodeJumpRequest    (decodeJumpRequest),
        .decodeJumpTarget     (decodeJumpTarget),
        .stall_fetch          (arb_stall_fetch),
        .stall_decode         (arb_stall_decode),
        .pcCTWriteEnable      (arb_ct_we),
        .controlTransferNewPC (arb_ct_pc),
        .flush_fetch          (arb_flush_fetch),
        .flush_decode         (arb_flush_decode)
    );

    // Only RUN consults the request inputs, so unknown inputs in INIT/HALT cannot reach the outputs.
    always_comb begin
        initialize           = 1'b0;
        stall_fetch          = 1'b0;
        pcCTWriteEnable      = 1'b0;
        controlTransferNewPC = '0;
        stall_decode         = 1'b0;
        flush_fetch          = 1'b0;
        flush_decode         = 1'b0;
        halted               = 1'b0;
        case (state)
            FS_RUN: begin
                stall_fetch          = arb_stall_fetch;
                pcCTWriteEnable      = arb_ct_we;
                controlTransferNewPC = arb_ct_pc;
                stall_decode         = arb_stall_decode;
                flush_fetch          = arb_flush_fetch;
                flush_decode         = arb_flush_decode;
            end
            FS_HALT: begin
                stall_fetch  = 1'b1;
                stall_decode = 1'b1;
                flush_decode = 1'b1;
                halted       = 1'b1;
            end
            default: begin
                initialize   = 1'b1;
                stall_decode = 1'b1;
                flush_fetch  = 1'b1;
                flush_decode = 1'b1;
            end
        endcase
    end

    assign bubble = flush_fetch | flush_decode | stall_fetch;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= FS_INIT;
            init_cnt    <= INIT_RELOAD;
            statBubbles <= '0;
        end else begin
            case (state)
                FS_INIT: begin
                    if (init_cnt == '0) begin
                        state <= FS_RUN;
                    end else begin
                        init_cnt <= init_cnt - 1'b1;
                    end
                end
                FS_RUN: begin
                    if (bubble && (statBubbles != '1)) begin
                        statBubbles <= statBubbles + 1'b1;
                    end
                    if (haltRequest) begin
                        state <= FS_HALT;
                    end
                end
                FS_HALT: begin
                    state <= FS_HALT;
                end
                default: begin
                    state    <= FS_INIT;
                    init_cnt <= INIT_RELOAD;
                end
            endcase
        end
    end

    a_no_redirect_while_stalled: assert property (
        @(posedge clock) disable iff (reset) !(pcCTWriteEnable && stall_fetch)
    );

endmodule

// File: tb/tb_jzjpcc_fetch_sequencer.sv
// Self-checking bench for jzjpcc_fetch_sequencer: directed cases plus random requests against a rule-level model.
module tb_jzjpcc_fetch_sequencer;

    localparam int PC_MAX_B    = 31;
    localparam int INIT_CYCLES = 2;
    localparam int STAT_W      = 4;
    localparam int STAT_MAX    = (1 << STAT_W) - 1;

    logic                clock = 1'b0;
    logic                reset;
    logic                decodeJumpRequest;
    logic [PC_MAX_B:2]   decodeJumpTarget;
    logic                executeBranchRequest;
    logic [PC_MAX_B:2]   executeBranchTarget;
    logic                loadUseHazard;
    logic                haltRequest;
    logic                initialize;
    logic                stall_fetch;
    logic                pcCTWriteEnable;
    logic [PC_MAX_B:2]   controlTransferNewPC;
    logic                stall_decode;
    logic                flush_fetch;
    logic                flush_decode;
    logic                halted;
    logic [STAT_W-1:0]   statBubbles;

    int compared   = 0;
    int mismatched = 0;

    // Model: mode 0 = priming after reset, 1 = running, 2 = halted
    int               modelMode;
    int               modelInitLeft;
    int               modelBubbles;
    logic [6:0]       expCtrl;
    logic [PC_MAX_B:2] expPC;

    jzjpcc_fetch_sequencer #(
        .PC_MAX_B    (PC_MAX_B),
        .INIT_CYCLES (INIT_CYCLES),
        .STAT_W      (STAT_W)
    ) dut (
        .clock                (clock),
        .reset                (reset),
        .decodeJumpRequest    (decodeJumpRequest),
        .decodeJumpTarget     (decodeJumpTarget),
        .executeBranchRequest (executeBranchRequest),
        .executeBranchTarget  (executeBranchTarget),
        .loadUseHazard        (loadUseHazard),
        .haltRequest          (haltRequest),
        .initialize           (initialize),
        .stall_fetch          (stall_fetch),
        .pcCTWriteEnable      (pcCTWriteEnable),
        .controlTransferNewPC (controlTransferNewPC),
        .stall_decode         (stall_decode),
        .flush_fetch          (flush_fetch),
        .flush_decode         (flush_decode),
        .halted               (halted),
        .statBubbles          (statBubbles)
    );

    always #5 clock = ~clock;

    // Expected outputs from the rules; ctrl = {initialize, stall_fetch, pcCTWriteEnable, stall_decode, flush_fetch, flush_decode, halted}
    task automatic computeExpected();
        expPC = '0;
        if (modelMode == 0) begin
            expCtrl = 7'b1001110;
        end else if (modelMode == 2) begin
            expCtrl = 7'b0101011;
        end else if (haltRequest) begin
            expCtrl = 7'b0101010;
        end else if (executeBranchRequest) begin
            expCtrl = 7'b0010110;
            expPC   = executeBranchTarget;
        end else if (loadUseHazard) begin
            expCtrl = 7'b0101010;
        end else if (decodeJumpRequest) begin
            expCtrl = 7'b0010100;
            expPC   = decodeJumpTarget;
        end else begin
            expCtrl = 7'b0000000;
        end
    endtask

    task automatic advanceModel();
        if (modelMode == 0) begin
            modelInitLeft--;
            if (modelInitLeft == 0) modelMode = 1;
        end else if (modelMode == 1) begin
            if ((expCtrl[5] || expCtrl[2] || expCtrl[1]) && modelBubbles < STAT_MAX) modelBubbles++;
            if (haltRequest) modelMode = 2;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [6:0] obsCtrl;
        obsCtrl = {initialize, stall_fetch, pcCTWriteEnable, stall_decode, flush_fetch, flush_decode, halted};
        computeExpected();
        compared++;
        assert (obsCtrl === expCtrl) else begin
            mismatched++;
            $error("[TB] FAIL %s ctrl: observed %b expected %b", tag, obsCtrl, expCtrl);
        end
        compared++;
        assert (controlTransferNewPC === expPC) else begin
            mismatched++;
            $error("[TB] FAIL %s newPC: observed %h expected %h", tag, controlTransferNewPC, expPC);
        end
        compared++;
        assert (statBubbles === STAT_W'(modelBubbles)) else begin
            mismatched++;
            $error("[TB] FAIL %s statBubbles: observed %0d expected %0d", tag, statBubbles, modelBubbles);
        end
    endtask

    // Inputs change 2 time units after a rising edge; checks happen 1 unit later, well clear of either edge.
    task automatic applyStimulus(input string tag, input logic j, input logic [PC_MAX_B:2] jt,
                                 input logic b, input logic [PC_MAX_B:2] bt,
                                 input logic lu, input logic h);
        decodeJumpRequest    = j;
        decodeJumpTarget     = jt;
        executeBranchRequest = b;
        executeBranchTarget  = bt;
        loadUseHazard        = lu;
        haltRequest          = h;
        #1;
        checkOutput(tag);
        @(posedge clock);
        advanceModel();
        #2;
    endtask

    task automatic randomStep(input string tag, input bit allowHalt);
        applyStimulus(tag,
                      1'($urandom_range(0, 1)), 30'($urandom),
                      1'($urandom_range(0, 3) == 0), 30'($urandom),
                      1'($urandom_range(0, 3) == 0),
                      allowHalt ? 1'($urandom_range(0, 1)) : 1'b0);
    endtask

    task automatic doReset(input string tag);
        reset         = 1'b1;
        modelMode     = 0;
        modelInitLeft = INIT_CYCLES;
        modelBubbles  = 0;
        #1;
        checkOutput(tag);
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        reset                = 1'b0;
        decodeJumpRequest    = 1'b0;
        decodeJumpTarget     = '0;
        executeBranchRequest = 1'b0;
        executeBranchTarget  = '0;
        loadUseHazard        = 1'b0;
        haltRequest          = 1'b0;
        #2;
        doReset("reset0");

        // Priming: requests must be ignored for exactly INIT_CYCLES cycles
        for (int i = 0; i < INIT_CYCLES; i++) randomStep("init", 1'b1);

        applyStimulus("branch_over_jump", 1'b1, 30'h100, 1'b1, 30'h040, 1'b0, 1'b0);
        applyStimulus("hazard_defers_jump", 1'b1, 30'h100, 1'b0, 30'h0, 1'b1, 1'b0);
        applyStimulus("jump_after_hazard", 1'b1, 30'h100, 1'b0, 30'h0, 1'b0, 1'b0);
        applyStimulus("idle", 1'b0, 30'h0, 1'b0, 30'h0, 1'b0, 1'b0);
        applyStimulus("branch_over_hazard", 1'b1, 30'h3ff, 1'b1, 30'h2aaa, 1'b1, 1'b0);

        for (int i = 0; i < 40; i++) randomStep("run_random", 1'b0);

        // Saturation from a fresh counter
        doReset("reset_sat");
        for (int i = 0; i < INIT_CYCLES; i++) randomStep("init_sat", 1'b0);
        for (int i = 0; i < 20; i++) applyStimulus("hazard_hold", 1'b0, 30'h0, 1'b0, 30'h0, 1'b1, 1'b0);
        compared++;
        assert (statBubbles === 4'd15) else begin
            mismatched++;
            $error("[TB] FAIL saturate: observed %0d expected 15", statBubbles);
        end

        for (int i = 0; i < 10; i++) randomStep("run_random2", 1'b0);
        applyStimulus("halt_with_branch", 1'b0, 30'h0, 1'b1, 30'h123, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++) randomStep("halt_random", 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus("halt_x", 1'bx, 'x, 1'bx, 'x, 1'bx, 1'bx);

        doReset("reset_in_halt");
        applyStimulus("init_x", 1'bx, 'x, 1'bx, 'x, 1'bx, 1'bx);
        for (int i = 1; i < INIT_CYCLES; i++) randomStep("reinit", 1'b1);
        for (int i = 0; i < 15; i++) randomStep("run_after_reinit", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/jzjpcc_fetch_sequencer.md
Name: jzjpcc_fetch_sequencer

Overview:
Control block that drives the fetch-stage program counter's `initialize`, `stall_fetch`, `pcCTWriteEnable` and `controlTransferNewPC` inputs. It holds fetch in initialization after reset while the instruction SRAM primes. It then arbitrates redirect requests from decode (jumps) and execute (branches), applies load-use stalls and halts, and generates the matching pipeline flush and stall controls. Outputs are Mealy (state plus inputs), so the PC's combinational `nextPC` can be captured by the imem address register in the same cycle.

Parameters:
- PC_MAX_B, 31, MSB of the word-aligned PC field [PC_MAX_B:2].
- INIT_CYCLES, 2, cycles `initialize` is held after reset release. Must be ≥1; 0 is illegal and is checked by an elaboration assertion.
- STAT_W, 16, width of the saturating bubble counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- decodeJumpRequest  in  1  JAL/JALR resolved in decode
- decodeJumpTarget  in  [PC_MAX_B:2]  jump target
- executeBranchRequest  in  1  taken branch or mispredict resolved in execute
- executeBranchTarget  in  [PC_MAX_B:2]  branch target
- loadUseHazard  in  1  decode instruction depends on a load in execute
- haltRequest  in  1  ECALL/EBREAK reached execute
- initialize  out  1  to PC; holds PC
- stall_fetch  out  1  to PC; holds PC
- pcCTWriteEnable  out  1  to PC; selects controlTransferNewPC
- controlTransferNewPC  out  [PC_MAX_B:2]  redirect target
- stall_decode  out  1  hold the fetch/decode pipeline register
- flush_fetch  out  1  squash the fetch/decode register (insert NOP)
- flush_decode  out  1  squash the decode/execute register (insert NOP)
- halted  out  1  core is in HALT state
- statBubbles  out  STAT_W  count of RUN cycles with any flush or stall

Behaviour:
- Reset is asynchronous, active-high; clock is `clock`.
- States: INIT, RUN, HALT. The state is held in a register, plus a $clog2(INIT_CYCLES+1)-bit down-counter.
- Reset values:
  - state = INIT, counter = INIT_CYCLES-1, statBubbles = 0.
  - Outputs during reset: initialize=1, flush_fetch=1, flush_decode=1, stall_decode=1; all other outputs 0.
- INIT:
  - Outputs are the reset values; all request inputs are ignored.
  - The counter decrements each cycle. When it is 0, go to RUN, giving exactly INIT_CYCLES cycles with initialize=1.
- RUN priority, highest first:
  1. haltRequest: go to HALT this edge. Outputs: stall_fetch=1, stall_decode=1, flush_decode=1. A branch in the same cycle is ignored (same instruction; halt wins).
  2. executeBranchRequest: pcCTWriteEnable=1, controlTransferNewPC=executeBranchTarget, flush_fetch=1, flush_decode=1. loadUseHazard and decodeJumpRequest are ignored because both belong to younger, squashed instructions.
  3. loadUseHazard: stall_fetch=1, stall_decode=1, flush_decode=1 (bubble). decodeJumpRequest is deferred and is re-presented next cycle by the held decode instruction.
  4. decodeJumpRequest: pcCTWriteEnable=1, controlTransferNewPC=decodeJumpTarget, flush_fetch=1.
  5. None of the above: all control outputs are 0 and the PC increments.
- pcCTWriteEnable and stall_fetch are never both 1 (enforced by an assertion).
- controlTransferNewPC = 0 whenever pcCTWriteEnable = 0.
- HALT:
  - Outputs: stall_fetch=1, stall_decode=1, flush_decode=1, halted=1.
  - All inputs are ignored. The block leaves HALT only on reset.
- statBubbles:
  - +1 on each RUN cycle where any of flush_fetch, flush_decode or stall_fetch is 1.
  - Saturates at all-ones; it does not increment in INIT or HALT.
- Reset asserted mid-operation, in any state: immediate return to INIT with the counter reloaded.
- An input X in INIT or HALT has no effect on the outputs.

Decomposition:
- Package jzjpcc_fetch_pkg:
  - typedef enum logic [1:0] {FS_INIT, FS_RUN, FS_HALT} fetchState_t
  - Localparam for the INIT counter width.
- One sub-module, jzjpcc_redirect_arbiter: combinational priority logic for RUN-state outputs (halt > branch > hazard > jump). The FSM, counter and stat counter stay in the top module.

Test Plan:
- Reset release with INIT_CYCLES=2 → initialize=1 for exactly 2 cycles, then 0; halted=0; statBubbles=0.
- RUN, executeBranchRequest=1 with target 0x040 and decodeJumpRequest=1 with target 0x100, same cycle → pcCTWriteEnable=1, controlTransferNewPC=0x040, flush_fetch=1, flush_decode=1.
- RUN, loadUseHazard=1 and decodeJumpRequest=1 → stall_fetch=1, pcCTWriteEnable=0, flush_decode=1. Next cycle with only the jump → pcCTWriteEnable=1, flush_fetch=1.
- haltRequest=1 for 1 cycle, then random requests for 20 cycles → halted=1 and stall_fetch=1 throughout; pcCTWriteEnable stays 0.
- reset pulse while in HALT → INIT again; initialize=1 for INIT_CYCLES; statBubbles=0.
- STAT_W=4 with loadUseHazard held high for 20 RUN cycles → statBubbles saturates at 15.
